// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath (add, addi, lw, sw, beq, j, syscall).
// Moore outputs decode from the state; syscall I/O uses a req/ack handshake with an optional timeout.
module multicycle_control #(
  parameter int OP_W       = 6,
  parameter int FUNCT_W    = 6,
  parameter int DATA_W     = 32,
  parameter int IO_TIMEOUT = 0,
  parameter int TMO_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  v0,
  input  logic               io_ack,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               io_req,
  output logic               io_dir,
  output logic               halted,
  output logic               illegal_op,
  output logic               io_timeout,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EXEC = 4'd11,
    ADDI_WB   = 4'd12,
    SYS_IO    = 4'd13,
    SYS_WB    = 4'd14,
    HALT      = 4'd15
  } state_t;

  localparam logic [OP_W-1:0]    OP_RTYPE  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0]    OP_LW     = OP_W'(6'b100011);
  localparam logic [OP_W-1:0]    OP_SW     = OP_W'(6'b101011);
  localparam logic [OP_W-1:0]    OP_BEQ    = OP_W'(6'b000100);
  localparam logic [OP_W-1:0]    OP_J      = OP_W'(6'b000010);
  localparam logic [OP_W-1:0]    OP_ADDI   = OP_W'(6'b001000);
  localparam logic [FUNCT_W-1:0] FN_ADD    = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SYSCALL = FUNCT_W'(6'b001100);
  localparam logic [DATA_W-1:0]  SYS_READ  = DATA_W'(5);
  localparam logic [DATA_W-1:0]  SYS_PRINT = DATA_W'(1);
  localparam logic [DATA_W-1:0]  SYS_EXIT  = DATA_W'(10);

  localparam int                TMO_LAST_I = (IO_TIMEOUT > 0) ? IO_TIMEOUT - 1 : 0;
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_LAST_I[TMO_W-1:0];

  state_t             state_q, state_d;
  logic               io_dir_q, io_dir_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               illegal_q, illegal_d;
  logic               io_timeout_q, io_timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      io_dir_q     <= 1'b0;
      tmo_cnt_q    <= '0;
      illegal_q    <= 1'b0;
      io_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      io_dir_q     <= io_dir_d;
      tmo_cnt_q    <= tmo_cnt_d;
      illegal_q    <= illegal_d;
      io_timeout_q <= io_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    io_dir_d      = io_dir_q;
    tmo_cnt_d     = tmo_cnt_q;
    illegal_d     = illegal_q;
    io_timeout_d  = io_timeout_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_source     = 2'd0;
    io_req        = 1'b0;
    io_dir        = 1'b0;
    halted        = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'd1;
        state_d   = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = MEM_ADDR;
        end else if (opcode == OP_BEQ) begin
          state_d = BRANCH;
        end else if (opcode == OP_J) begin
          state_d = JUMP;
        end else if (opcode == OP_ADDI) begin
          state_d = ADDI_EXEC;
        end else if (opcode == OP_RTYPE && funct == FN_ADD) begin
          state_d = R_EXEC;
        end else if (opcode == OP_RTYPE && funct == FN_SYSCALL) begin
          // Unknown syscall services are treated as no-ops, not as illegal.
          tmo_cnt_d = '0;
          if (v0 == SYS_READ) begin
            io_dir_d = 1'b1;
            state_d  = SYS_IO;
          end else if (v0 == SYS_PRINT) begin
            io_dir_d = 1'b0;
            state_d  = SYS_IO;
          end else if (v0 == SYS_EXIT) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
          end
        end else begin
          illegal_d = 1'b1;
          state_d   = FETCH;
        end
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        state_d   = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      SYS_IO: begin
        io_req = 1'b1;
        io_dir = io_dir_q;
        // An ack arriving on the final allowed cycle takes priority over the timeout.
        if (io_ack) begin
          state_d = io_dir_q ? SYS_WB : FETCH;
        end else if (IO_TIMEOUT > 0 && tmo_cnt_q == TMO_LAST) begin
          io_timeout_d = 1'b1;
          state_d      = FETCH;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      SYS_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        state_d    = FETCH;
      end
      HALT: begin
        halted  = 1'b1;
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign illegal_op = illegal_q;
  assign io_timeout = io_timeout_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class state by state
// and compares the state and packed control outputs against hand-written values.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] v0;
  logic        io_ack;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic        alu_src_a, io_req, io_dir, halted, illegal_op, io_timeout;
  logic [3:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control #(
    .OP_W(6), .FUNCT_W(6), .DATA_W(32), .IO_TIMEOUT(8), .TMO_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .v0(v0), .io_ack(io_ack),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .io_req(io_req), .io_dir(io_dir), .halted(halted),
    .illegal_op(illegal_op), .io_timeout(io_timeout), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] ctl_obs;
  assign ctl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
                    io_req, io_dir, halted};

  function automatic logic [20:0] mk(
    input logic pw, pwc, iod, mr, mw, irw, rw,
    input logic [1:0] rd, mtr,
    input logic asa,
    input logic [1:0] asb, aop, psrc,
    input logic req, dir, hlt);
    return {pw, pwc, iod, mr, mw, irw, rw, rd, mtr, asa, asb, aop, psrc, req, dir, hlt};
  endfunction

  logic [20:0] C_FETCH, C_DECODE, C_MADDR, C_MREAD, C_MWB, C_MWRITE, C_REXEC, C_RWB;
  logic [20:0] C_BRANCH, C_JUMP, C_AEXEC, C_AWB, C_SYSIN, C_SYSOUT, C_SYSWB, C_HALT;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Check the present state and outputs, then advance one clock.
  task automatic step(input string tag, input logic [3:0] st, input logic [20:0] c);
    check_eq({tag, ":state"}, 32'(state), 32'(st));
    check_eq({tag, ":ctl"}, 32'(ctl_obs), 32'(c));
    @(negedge clk);
  endtask

  task automatic load(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] val);
    opcode = op;
    funct  = fn;
    v0     = val;
  endtask

  initial begin
    //               pw pwc iod mr mw irw rw rd   mtr  asa asb  aop  psrc req dir hlt
    C_FETCH  = mk(1, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 2'd1, 2'd0, 2'd0, 0, 0, 0);
    C_DECODE = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd3, 2'd0, 2'd0, 0, 0, 0);
    C_MADDR  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 2'd0, 2'd0, 0, 0, 0);
    C_MREAD  = mk(0, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    C_MWB    = mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    C_MWRITE = mk(0, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    C_REXEC  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 2'd2, 2'd0, 0, 0, 0);
    C_RWB    = mk(0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    C_BRANCH = mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 2'd1, 2'd1, 0, 0, 0);
    C_JUMP   = mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 2'd2, 0, 0, 0);
    C_AEXEC  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 2'd0, 2'd0, 0, 0, 0);
    C_AWB    = mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    C_SYSIN  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 1, 1, 0);
    C_SYSOUT = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 1, 0, 0);
    C_SYSWB  = mk(0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    C_HALT   = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 1);

    rst_n = 1'b0; io_ack = 1'b0;
    load(6'b000000, 6'b000000, 32'd0);
    @(negedge clk); @(negedge clk);
    check_eq("rst:state", 32'(state), 32'd0);
    check_eq("rst:ctl", 32'(ctl_obs), 32'd0);
    check_eq("rst:illegal", 32'(illegal_op), 32'd0);
    check_eq("rst:timeout", 32'(io_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    load(6'b100011, 6'b000000, 32'd0);               // lw: 5 cycles
    step("lw", 4'd1, C_FETCH);  step("lw", 4'd2, C_DECODE); step("lw", 4'd3, C_MADDR);
    step("lw", 4'd4, C_MREAD);  step("lw", 4'd5, C_MWB);

    load(6'b101011, 6'b000000, 32'd0);               // sw: 4 cycles
    step("sw", 4'd1, C_FETCH);  step("sw", 4'd2, C_DECODE); step("sw", 4'd3, C_MADDR);
    step("sw", 4'd6, C_MWRITE);

    load(6'b000000, 6'b100000, 32'd0);               // add, reset during R_WB
    step("add", 4'd1, C_FETCH); step("add", 4'd2, C_DECODE); step("add", 4'd7, C_REXEC);
    check_eq("add:rwb_state", 32'(state), 32'd8);
    check_eq("add:rwb_ctl", 32'(ctl_obs), 32'(C_RWB));
    rst_n = 1'b0;
    #1;
    check_eq("midrst:state", 32'(state), 32'd0);
    check_eq("midrst:ctl", 32'(ctl_obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load(6'b001000, 6'b000000, 32'd0);               // addi
    step("addi", 4'd1, C_FETCH); step("addi", 4'd2, C_DECODE);
    step("addi", 4'd11, C_AEXEC); step("addi", 4'd12, C_AWB);

    load(6'b000100, 6'b000000, 32'd0);               // beq: 3 cycles
    step("beq", 4'd1, C_FETCH); step("beq", 4'd2, C_DECODE); step("beq", 4'd9, C_BRANCH);
    load(6'b000010, 6'b000000, 32'd0);               // j: 3 cycles
    step("j", 4'd1, C_FETCH); step("j", 4'd2, C_DECODE); step("j", 4'd10, C_JUMP);

    load(6'b000000, 6'b001100, 32'd5);               // read int, ack on 4th wait cycle
    step("rdint", 4'd1, C_FETCH); step("rdint", 4'd2, C_DECODE);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) io_ack = 1'b1;
      step("rdint_io", 4'd13, C_SYSIN);
    end
    io_ack = 1'b0;
    step("rdint_wb", 4'd14, C_SYSWB);

    load(6'b000000, 6'b001100, 32'd1);               // print int, ack on 8th (last) cycle
    step("prack", 4'd1, C_FETCH); step("prack", 4'd2, C_DECODE);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) io_ack = 1'b1;
      step("prack_io", 4'd13, C_SYSOUT);
    end
    io_ack = 1'b0;
    check_eq("prack:timeout", 32'(io_timeout), 32'd0);

    step("prtmo", 4'd1, C_FETCH); step("prtmo", 4'd2, C_DECODE); // print int, never acked
    for (int i = 0; i < 8; i++) step("prtmo_io", 4'd13, C_SYSOUT);
    check_eq("prtmo:timeout", 32'(io_timeout), 32'd1);

    load(6'b000000, 6'b001100, 32'd7);               // unknown service: no-op
    step("nop", 4'd1, C_FETCH); step("nop", 4'd2, C_DECODE);
    check_eq("nop:illegal", 32'(illegal_op), 32'd0);

    load(6'b111111, 6'b000000, 32'd0);               // illegal opcode
    step("ill", 4'd1, C_FETCH); step("ill", 4'd2, C_DECODE);
    check_eq("ill:flag", 32'(illegal_op), 32'd1);
    load(6'b000010, 6'b000000, 32'd0);
    step("ill_j", 4'd1, C_FETCH); step("ill_j", 4'd2, C_DECODE); step("ill_j", 4'd10, C_JUMP);
    check_eq("ill:sticky", 32'(illegal_op), 32'd1);
    check_eq("tmo:sticky", 32'(io_timeout), 32'd1);

    load(6'b000000, 6'b001100, 32'd10);              // exit
    step("exit", 4'd1, C_FETCH); step("exit", 4'd2, C_DECODE);
    io_ack = 1'b1;
    for (int i = 0; i < 20; i++) step("halt", 4'd15, C_HALT);
    io_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("hrst:state", 32'(state), 32'd0);
    check_eq("hrst:illegal", 32'(illegal_op), 32'd0);
    check_eq("hrst:timeout", 32'(io_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step("post", 4'd1, C_FETCH);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS main control FSM. Drives the shared-memory multi-cycle datapath: PC, IR, register file, ALU muxes and memory.
- Supports add, addi, lw, sw, beq, j and syscall.
- Syscall services are read-integer (v0=5), print-integer (v0=1) and exit (v0=10), each via a req/ack handshake to the board I/O unit.
- Sits between the IR/register file and the datapath muxes; the ALU control decoder consumes alu_op.

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, funct field width
DATA_W, 32, width of v0 operand
IO_TIMEOUT, 0, max cycles to wait for io_ack; 0 disables timeout
TMO_W, 16, width of timeout counter (IO_TIMEOUT < 2^TMO_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OP_W  IR[31:26]
funct  in  FUNCT_W  IR[5:0]
v0  in  DATA_W  register $2 read value
io_ack  in  1  I/O unit completion
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  0=PC address, 1=ALUOut address
mem_read  out  1  memory read
mem_write  out  1  memory write
ir_write  out  1  IR load
reg_write  out  1  register file write
reg_dst  out  2  0=rt, 1=rd, 2=$v0
mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=io_data
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=imm<<2
alu_op  out  2  0=add, 1=sub, 2=funct
pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target
io_req  out  1  syscall I/O request
io_dir  out  1  1=input (read int), 0=output (print $a0)
halted  out  1  exit executed
illegal_op  out  1  sticky: undefined opcode or funct seen
io_timeout  out  1  sticky: IO wait exceeded IO_TIMEOUT
state  out  4  current state (debug)

Behaviour:
- Clocking and outputs: Moore FSM, 4-bit state register. All control outputs decode from the state; each output not listed for a state is 0.
- Reset: rst_n low forces state=IDLE(0). Also clears io_dir, the timeout counter, illegal_op and io_timeout. In IDLE every output is 0. Reset mid-instruction aborts it with no further writes.
- IDLE -> FETCH unconditionally.
- FETCH(1): mem_read, ir_write, pc_write, alu_src_b=1. -> DECODE.
- DECODE(2): alu_src_b=3. Next state by opcode:
  - 100011/101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - 000000 with funct 100000 -> R_EXEC
  - 000000 with funct 001100 -> syscall by v0 (sampled this cycle):
    - v0=5: io_dir<=1, -> SYS_IO
    - v0=1: io_dir<=0, -> SYS_IO
    - v0=10: -> HALT
    - other v0: -> FETCH (no-op)
  - anything else: illegal_op<=1, -> FETCH.
- MEM_ADDR(3): alu_src_a=1, alu_src_b=2. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ(4): mem_read, i_or_d. -> MEM_WB.
- MEM_WB(5): reg_write, reg_dst=0, mem_to_reg=1. -> FETCH.
- MEM_WRITE(6): mem_write, i_or_d. -> FETCH.
- R_EXEC(7): alu_src_a=1, alu_op=2. -> R_WB.
- R_WB(8): reg_write, reg_dst=1. -> FETCH.
- BRANCH(9): alu_src_a=1, alu_op=1, pc_write_cond, pc_source=1. -> FETCH.
- JUMP(10): pc_write, pc_source=2. -> FETCH.
- ADDI_EXEC(11): alu_src_a=1, alu_src_b=2. -> ADDI_WB.
- ADDI_WB(12): reg_write, reg_dst=0. -> FETCH.
- SYS_IO(13): io_req=1 and io_dir held stable until leaving.
  - io_ack high: input -> SYS_WB, output -> FETCH.
  - Counter increments each SYS_IO cycle without ack; cleared on entering SYS_IO.
  - IO_TIMEOUT>0 and counter reaches IO_TIMEOUT-1 without ack: io_timeout<=1, -> FETCH.
  - Ack on that same cycle wins; timeout not flagged.
  - io_ack outside SYS_IO is ignored.
- SYS_WB(14): reg_write, reg_dst=2, mem_to_reg=2. -> FETCH.
- HALT(15): halted=1, all other control outputs 0. Stays until reset.
- Sticky flags clear only on reset.
- Per-instruction cycle counts: lw 5, sw 4, add/addi 4, beq/j 3, syscall I/O 3+wait(+1 if input).

Test Plan:
- Reset: drive rst_n=0 mid-R_WB -> state=0 immediately and all outputs 0; after release, FETCH with mem_read=ir_write=pc_write=1, alu_src_b=1.
- lw (opcode 100011) -> states 1,2,3,4,5,1; MEM_WB shows reg_write=1, mem_to_reg=1, reg_dst=0.
- beq then j -> BRANCH pc_write_cond=1, alu_op=1, pc_source=1; JUMP pc_write=1, pc_source=2, each 3 cycles total.
- Syscall v0=5, io_ack after 4 cycles -> io_req=1, io_dir=1 for 4 cycles; then SYS_WB with reg_dst=2, mem_to_reg=2, reg_write=1; then FETCH.
- IO_TIMEOUT=8, syscall v0=1, no ack -> io_req high 8 cycles, io_timeout=1, FETCH. Repeat with ack on the 8th cycle -> io_timeout stays 0.
- Opcode 111111 -> illegal_op=1 stays set across later valid instructions. Syscall v0=10 -> halted=1, state=15 held for 20 cycles; only reset exits.
